cla_add_pipe: RTL and testbench

- Two-stage pipelined carry-lookahead adder. It is the addition counterpart to the borrow-lookahead subtractor datapath.
- Uses carry-propagate/generate terms: p = a | b, g = a & b.
- Operands enter through a valid/ready handshake. Sum, carry-out and signed overflow leave through a second valid/ready handshake.
- Sits in the arithmetic datapath beside the subtractor. It supplies the add half of the ALU and accumulator paths.

---
 rtl/cla_add_pipe_pkg.sv | 23 ++
 rtl/cla_add_pipe_if.sv | 38 +++
 rtl/cla_add_pipe_cla_grp4.sv | 27 ++
 rtl/cla_add_pipe.sv | 168 ++++++++++++++++
 tb/tb_cla_add_pipe.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cla_add_pipe_pkg.sv
// -----------------------------------------------------------------------------
// cla_add_pipe_pkg
//   Shared arithmetic definitions for the lookahead adder and subtractor
//   datapaths.
//   - GRP_W   : lookahead group width in bits (fixed at 4).
//   - ngrp()  : number of lookahead groups for a given operand width.
//   - add_ovf : two's-complement overflow rule for a + b.
// -----------------------------------------------------------------------------
package cla_add_pipe_pkg;

    localparam int GRP_W = 4;

    // Number of GRP_W-bit lookahead groups covering a WIDTH-bit operand.
    function automatic int ngrp(input int width);
        return width / GRP_W;
    endfunction

    // Signed overflow: both operands share a sign and the result's sign differs.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/cla_add_pipe_if.sv
// -----------------------------------------------------------------------------
// cla_add_pipe_if
//   Operand and result handshake bundle for cla_add_pipe.
//   Operand side : in_valid, in_ready, a, b, cin
//   Result side  : out_valid, out_ready, sum, cout, ovf
//   Modports:
//   - master : the producer of operands / consumer of results.
//   - slave  : the adder itself.
//
//   Handshake: a beat transfers on a rising clk edge where valid and ready are
//   both 1. A producer holds valid and its data until the transfer; the adder's
//   result fields hold stable while out_valid=1 and out_ready=0. in_ready never
//   depends on in_valid.
// -----------------------------------------------------------------------------
interface cla_add_pipe_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/cla_add_pipe_cla_grp4.sv
// -----------------------------------------------------------------------------
// cla_grp4
//   Combinational 4-bit carry-lookahead group.
//   Inputs : p[3:0], g[3:0] per-bit propagate/generate, cin group carry-in.
//   Outputs: p_grp (group propagate), g_grp (group generate),
//            c[3:1] carries into bits 1..3 of the group.
// -----------------------------------------------------------------------------
module cla_grp4 (
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       cin,
    output logic       p_grp,
    output logic       g_grp,
    output logic [3:1] c
);

    assign p_grp = &p;
    assign g_grp = g[3]
                 | (p[3] & g[2])
                 | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);

    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

endmodule

// File: rtl/cla_add_pipe.sv
// -----------------------------------------------------------------------------
// cla_add_pipe
//   Two-stage pipelined carry-lookahead adder: sum = a + b + cin mod 2^WIDTH,
//   with carry-out and signed overflow.
//   Ports:
//   - clk : rising-edge clock.
//   - rst : synchronous, active-high reset; drops all in-flight beats.
//   - bus : cla_add_pipe_if.slave (operand and result handshakes).
//   Stage 1 registers per-bit p/g, group P/G, half-sum, cin and operand MSBs.
//   Stage 2 resolves group and intra-group carries and registers the result.
// -----------------------------------------------------------------------------
module cla_add_pipe
    import cla_add_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GRP   = 4
) (
    input  logic               clk,
    input  logic               rst,
    cla_add_pipe_if.slave      bus
);

    localparam int NGRP = ngrp(WIDTH);

    if (GRP != GRP_W || (WIDTH % GRP_W) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_cfg
        $error("cla_add_pipe: WIDTH must be a multiple of 4 in 4..64 and GRP must be 4");
    end

    // ---------------- pipeline control ----------------
    logic s1_valid;
    logic out_valid_q;
    logic s2_adv;
    logic s1_adv;
    logic in_fire;

    // S2 can take a beat when empty or when its beat leaves this cycle;
    // S1 can then take a beat when empty or when it moves into S2.
    assign s2_adv  = ~out_valid_q | bus.out_ready;
    assign s1_adv  = ~s1_valid | s2_adv;
    assign in_fire = bus.in_valid & s1_adv;

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = out_valid_q;

    // ---------------- stage 1 combinational ----------------
    logic [WIDTH-1:0]  p_in;
    logic [WIDTH-1:0]  g_in;
    logic [NGRP-1:0]   grp_p_in;
    logic [NGRP-1:0]   grp_g_in;
    logic [NGRP*3-1:0] unused_s1_c;

    assign p_in = bus.a | bus.b;
    assign g_in = bus.a & bus.b;

    for (genvar k = 0; k < NGRP; k++) begin : g_s1_grp
        // Only the group terms are used here; carries are resolved in S2.
        cla_grp4 u_grp (
            .p     (p_in[k*4 +: 4]),
            .g     (g_in[k*4 +: 4]),
            .cin   (1'b0),
            .p_grp (grp_p_in[k]),
            .g_grp (grp_g_in[k]),
            .c     (unused_s1_c[k*3 +: 3])
        );
    end

    // ---------------- stage 1 registers ----------------
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    logic [WIDTH-1:0] s1_hs;
    logic [NGRP-1:0]  s1_gp;
    logic [NGRP-1:0]  s1_gg;
    logic             s1_cin;
    logic             s1_a_msb;
    logic             s1_b_msb;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_hs    <= '0;
            s1_gp    <= '0;
            s1_gg    <= '0;
            s1_cin   <= 1'b0;
            s1_a_msb <= 1'b0;
            s1_b_msb <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_fire;
            end
            if (in_fire) begin
                s1_p     <= p_in;
                s1_g     <= g_in;
                s1_hs    <= bus.a ^ bus.b;
                s1_gp    <= grp_p_in;
                s1_gg    <= grp_g_in;
                s1_cin   <= bus.cin;
                s1_a_msb <= bus.a[WIDTH-1];
                s1_b_msb <= bus.b[WIDTH-1];
            end
        end
    end

    // ---------------- stage 2 combinational ----------------
    logic [NGRP:0]     gc;
    logic [NGRP*3-1:0] cg;
    logic [NGRP-1:0]   unused_s2_p;
    logic [NGRP-1:0]   unused_s2_g;
    logic [WIDTH-1:0]  carry;
    logic [WIDTH-1:0]  sum_next;
    logic              cout_next;
    logic              ovf_next;

    // Group-level carry chain from the registered group P/G terms.
    always_comb begin
        gc    = '0;
        gc[0] = s1_cin;
        for (int k = 0; k < NGRP; k++) begin
            gc[k+1] = s1_gg[k] | (s1_gp[k] & gc[k]);
        end
    end

    for (genvar k = 0; k < NGRP; k++) begin : g_s2_grp
        cla_grp4 u_grp (
            .p     (s1_p[k*4 +: 4]),
            .g     (s1_g[k*4 +: 4]),
            .cin   (gc[k]),
            .p_grp (unused_s2_p[k]),
            .g_grp (unused_s2_g[k]),
            .c     (cg[k*3 +: 3])
        );
        // Bit 0 of each group takes the group carry; bits 1..3 the intra-group carries.
        assign carry[k*4 +: 4] = {cg[k*3 +: 3], gc[k]};
    end

    assign sum_next  = s1_hs ^ carry;
    assign cout_next = gc[NGRP];
    assign ovf_next  = add_ovf(s1_a_msb, s1_b_msb, sum_next[WIDTH-1]);

    // ---------------- stage 2 / output registers ----------------
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (s2_adv) begin
            // Loading only when a beat arrives keeps the last result in place
            // after it is popped with nothing behind it.
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                sum_q  <= sum_next;
                cout_q <= cout_next;
                ovf_q  <= ovf_next;
            end
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_cla_add_pipe.sv
// -----------------------------------------------------------------------------
// tb_cla_add_pipe
//   Directed bench for cla_add_pipe with a result scoreboard. Expected
//   {ovf, cout, sum} words are queued when an operand beat is accepted and
//   compared whenever the adder presents a result.
// -----------------------------------------------------------------------------
module tb_cla_add_pipe;

    localparam int WIDTH = 16;
    localparam int W     = WIDTH + 2;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [W-1:0] exp_q[$];
    int           pop_cyc[$];

    cla_add_pipe_if #(.WIDTH(WIDTH)) bus ();

    cla_add_pipe #(.WIDTH(WIDTH), .GRP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic c);
        logic [WIDTH:0] t;
        logic           v;
        t = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
        v = (a[WIDTH-1] == b[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
        return {v, t[WIDTH], t[WIDTH-1:0]};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    // Sampled on the falling edge: a result seen here with out_ready=1
    // transfers on the next rising edge. While stalled, the presented result
    // is compared against the queue head every cycle.
    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_beat: got result %h, expected no beat",
                           {bus.ovf, bus.cout, bus.sum});
                end
            end else begin
                check("result", {bus.ovf, bus.cout, bus.sum}, exp_q[0]);
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    pop_cyc.push_back(cyc);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Entered just after a rising edge; returns just after the edge on which
    // the beat transferred, leaving in_valid asserted for back-to-back use.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = c;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(model(a, b, c));
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        assert (ok) else begin
            errors++;
            $error("FAIL send_timeout: got in_ready=0 for 50 cycles, expected acceptance");
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL %s: got %0d beats pending, expected 0", tag, exp_q.size());
        end
    endtask

    // ---------------- directed sequence ----------------
    logic [WIDTH-1:0] ta, tb;
    logic             tc;
    bit               have;

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", W'(bus.out_valid), W'(0));
        check("rst_result", {bus.ovf, bus.cout, bus.sum}, W'(0));
        check("rst_in_ready", W'(bus.in_ready), W'(1));
        @(posedge clk);
        #1;

        // Single beat and latency: presented in cycle 0, out_valid in cycle 2
        send(16'h1234, 16'h4321, 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("lat_cycle1_out_valid", W'(bus.out_valid), W'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("lat_cycle2_out_valid", W'(bus.out_valid), W'(1));
        check("lat_cycle2_result", {bus.ovf, bus.cout, bus.sum}, {1'b0, 1'b0, 16'h5555});
        @(posedge clk);
        #1;
        drain("single_drain");

        // Full carry ripple and signed overflow
        send(16'hFFFF, 16'h0000, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0);
        bus.in_valid = 1'b0;
        drain("ripple_drain");

        // Back-to-back stream
        pop_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            send(16'(i * 16'h1111), 16'h0F0F, i[0]);
        end
        bus.in_valid = 1'b0;
        drain("stream_drain");
        check("stream_beats", W'(pop_cyc.size()), W'(8));
        if (pop_cyc.size() == 8) begin
            check("stream_span", W'(pop_cyc[7] - pop_cyc[0]), W'(7));
        end

        // Backpressure: two beats fill the pipe, the third waits
        bus.out_ready = 1'b0;
        send(16'hA5A5, 16'h5A5A, 1'b1);
        send(16'h8000, 16'h8000, 1'b0);
        bus.a   = 16'h0123;
        bus.b   = 16'hFEDC;
        bus.cin = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready", W'(bus.in_ready), W'(0));
            check("bp_out_valid", W'(bus.out_valid), W'(1));
            @(posedge clk);
            #1;
        end
        check("bp_held_beats", W'(exp_q.size()), W'(2));
        bus.out_ready = 1'b1;
        send(16'h0123, 16'hFEDC, 1'b1);
        bus.in_valid = 1'b0;
        drain("bp_drain");

        // out_ready toggling every cycle with a continuous producer
        have = 1'b0;
        for (int k = 0; k < 24; k++) begin
            bus.out_ready = k[0];
            if (!have) begin
                ta   = 16'($urandom_range(0, 16'hFFFF));
                tb   = 16'($urandom_range(0, 16'hFFFF));
                tc   = 1'($urandom_range(0, 1));
                have = 1'b1;
            end
            bus.in_valid = 1'b1;
            bus.a        = ta;
            bus.b        = tb;
            bus.cin      = tc;
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(model(ta, tb, tc));
                have = 1'b0;
            end
            if (k >= 3) begin
                check("toggle_out_valid", W'(bus.out_valid), W'(1));
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain("toggle_drain");

        // Reset with two beats held under stall
        bus.out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0);
        send(16'h3333, 16'h4444, 1'b1);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", W'(bus.out_valid), W'(0));
        check("midrst_result", {bus.ovf, bus.cout, bus.sum}, W'(0));
        check("midrst_in_ready", W'(bus.in_ready), W'(1));
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        send(16'h00FF, 16'h0001, 1'b0);
        bus.in_valid = 1'b0;
        drain("midrst_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
